// File: rtl/pipe_ctrl.sv
// pipe_ctrl: merges per-stage stall requests into the pipeline hold vector,
// sequences exception flushes (draining older stages first) and keeps
// saturating stall/flush performance counters.
module pipe_ctrl #(
  parameter int NSTAGE    = 6,
  parameter int EXC_STAGE = 4,
  parameter int CNT_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSTAGE-1:0] stallreq,
  input  logic              exc_req,
  input  logic [31:0]       exc_pc,
  input  logic              cnt_clr,
  output logic [NSTAGE-1:0] stall,
  output logic              flush,
  output logic [31:0]       flush_pc,
  output logic              busy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FLUSH} state_t;

  // Stages at and below the faulting stage hold while an exception is pending;
  // everything older keeps draining.
  localparam logic [NSTAGE-1:0] EXC_MASK = {NSTAGE{1'b1}} >> (NSTAGE - 1 - EXC_STAGE);

  state_t           state_q, state_d;
  logic [31:0]      pend_q, pend_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [NSTAGE-1:0] base;
  logic             old_busy;

  // A stall at stage k must also freeze every younger stage below it.
  for (genvar j = 0; j < NSTAGE; j++) begin : g_base
    assign base[j] = |stallreq[NSTAGE-1:j];
  end

  assign old_busy = |stallreq[NSTAGE-1:EXC_STAGE+1];

  // Next-state, pending PC capture and the combinational hold vector.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    stall   = base;
    unique case (state_q)
      S_IDLE: begin
        if (exc_req) begin
          pend_d  = exc_pc;
          stall   = base | EXC_MASK;
          state_d = old_busy ? S_WAIT : S_FLUSH;
        end
      end
      S_WAIT: begin
        stall = base | EXC_MASK;
        if (!old_busy) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        stall   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (rst) stall = '0;
  end

  // Saturating counters; clear takes priority over a same-cycle increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall[0] && stall_cnt_q != {CNT_W{1'b1}}) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (state_q == S_FLUSH && flush_cnt_q != {CNT_W{1'b1}}) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    if (cnt_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end
  end

  // State, pending PC and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pend_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign flush     = (state_q == S_FLUSH);
  assign flush_pc  = pend_q;
  assign busy      = (state_q != S_IDLE);
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with 4-bit counters so saturation is reachable.
module tb_pipe_ctrl;
  localparam int NSTAGE = 6;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [NSTAGE-1:0] stallreq;
  logic              exc_req;
  logic [31:0]       exc_pc;
  logic              cnt_clr;
  logic [NSTAGE-1:0] stall;
  logic              flush;
  logic [31:0]       flush_pc;
  logic              busy;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_ctrl #(.NSTAGE(NSTAGE), .EXC_STAGE(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .stallreq(stallreq), .exc_req(exc_req), .exc_pc(exc_pc),
    .cnt_clr(cnt_clr), .stall(stall), .flush(flush), .flush_pc(flush_pc),
    .busy(busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stallreq = 6'b111111; exc_req = 1'b1; exc_pc = 32'hDEAD_BEEF; cnt_clr = 1'b0;
    step(); step();
    #1;
    n_tests++; if (stall !== 6'b000000) begin n_fail++; $display("FAIL reset_stall got %b want 000000", stall); end
    n_tests++; if (flush !== 1'b0) begin n_fail++; $display("FAIL reset_flush got %b want 0", flush); end
    n_tests++; if (flush_pc !== 32'h0) begin n_fail++; $display("FAIL reset_flush_pc got %h want 0", flush_pc); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_cnt got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
    rst = 1'b0; stallreq = '0; exc_req = 1'b0; exc_pc = '0;
    step();
  endtask

  task automatic test_load_stall();
    stallreq = 6'b000100; #1;
    n_tests++; if (stall !== 6'b000111) begin n_fail++; $display("FAIL load_stall got %b want 000111", stall); end
    n_tests++; if (flush !== 1'b0 || stall_cnt !== 4'd0) begin n_fail++; $display("FAIL load_pre flush=%b cnt=%0d want 0/0", flush, stall_cnt); end
    step(); stallreq = '0; #1;
    n_tests++; if (stall_cnt !== 4'd1 || stall !== 6'b000000) begin n_fail++; $display("FAIL load_post cnt=%0d stall=%b want 1/000000", stall_cnt, stall); end
  endtask

  task automatic test_combined();
    stallreq = 6'b001100; #1;
    n_tests++; if (stall !== 6'b001111) begin n_fail++; $display("FAIL combined got %b want 001111", stall); end
    step(); stallreq = 6'b010000; #1;
    n_tests++; if (stall !== 6'b011111) begin n_fail++; $display("FAIL mem_stall got %b want 011111", stall); end
    step(); stallreq = '0; #1;
    n_tests++; if (stall_cnt !== 4'd3) begin n_fail++; $display("FAIL combined_cnt got %0d want 3", stall_cnt); end
  endtask

  task automatic test_clean_exc();
    exc_req = 1'b1; exc_pc = 32'hBFC0_0380; #1;
    n_tests++; if (stall !== 6'b011111 || busy !== 1'b0) begin n_fail++; $display("FAIL exc_accept stall=%b busy=%b want 011111/0", stall, busy); end
    step(); exc_req = 1'b0; stallreq = 6'b111111; #1;
    n_tests++; if (flush !== 1'b1 || flush_pc !== 32'hBFC0_0380) begin n_fail++; $display("FAIL exc_flush flush=%b pc=%h want 1/bfc00380", flush, flush_pc); end
    n_tests++; if (stall !== 6'b000000 || busy !== 1'b1) begin n_fail++; $display("FAIL exc_flush_stall stall=%b busy=%b want 000000/1", stall, busy); end
    n_tests++; if (flush_cnt !== 4'd0) begin n_fail++; $display("FAIL exc_flush_cnt_pre got %0d want 0", flush_cnt); end
    step(); stallreq = '0; #1;
    n_tests++; if (busy !== 1'b0 || flush !== 1'b0 || flush_cnt !== 4'd1) begin n_fail++; $display("FAIL exc_done busy=%b flush=%b fcnt=%0d want 0/0/1", busy, flush, flush_cnt); end
    n_tests++; if (stall_cnt !== 4'd4) begin n_fail++; $display("FAIL exc_stall_cnt got %0d want 4", stall_cnt); end
  endtask

  task automatic test_drain();
    exc_req = 1'b1; exc_pc = 32'hA000_0000; stallreq = 6'b100000; #1;
    n_tests++; if (stall !== 6'b111111 || busy !== 1'b0) begin n_fail++; $display("FAIL drain_accept stall=%b busy=%b want 111111/0", stall, busy); end
    step(); exc_pc = 32'h0000_1234;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_tests++; if (stall !== 6'b111111 || busy !== 1'b1 || flush !== 1'b0) begin n_fail++; $display("FAIL drain_wait%0d stall=%b busy=%b flush=%b want 111111/1/0", i, stall, busy, flush); end
      step();
    end
    exc_req = 1'b0; stallreq = '0; #1;
    n_tests++; if (stall !== 6'b011111 || busy !== 1'b1 || flush !== 1'b0) begin n_fail++; $display("FAIL drain_last stall=%b busy=%b flush=%b want 011111/1/0", stall, busy, flush); end
    step(); #1;
    n_tests++; if (flush !== 1'b1 || flush_pc !== 32'hA000_0000) begin n_fail++; $display("FAIL drain_flush flush=%b pc=%h want 1/a0000000", flush, flush_pc); end
    step(); #1;
    n_tests++; if (flush_cnt !== 4'd2 || stall_cnt !== 4'd9 || busy !== 1'b0) begin n_fail++; $display("FAIL drain_cnt fcnt=%0d scnt=%0d busy=%b want 2/9/0", flush_cnt, stall_cnt, busy); end
  endtask

  task automatic test_back_to_back();
    exc_req = 1'b1; exc_pc = 32'h0000_0100;
    step(); exc_pc = 32'h0000_0200; #1;
    n_tests++; if (flush !== 1'b1 || flush_pc !== 32'h0000_0100) begin n_fail++; $display("FAIL b2b_first flush=%b pc=%h want 1/00000100", flush, flush_pc); end
    step(); #1;
    n_tests++; if (stall !== 6'b011111 || busy !== 1'b0 || flush !== 1'b0) begin n_fail++; $display("FAIL b2b_reaccept stall=%b busy=%b flush=%b want 011111/0/0", stall, busy, flush); end
    step(); exc_req = 1'b0; #1;
    n_tests++; if (flush !== 1'b1 || flush_pc !== 32'h0000_0200) begin n_fail++; $display("FAIL b2b_second flush=%b pc=%h want 1/00000200", flush, flush_pc); end
    step(); #1;
    n_tests++; if (flush_cnt !== 4'd4 || stall_cnt !== 4'd11) begin n_fail++; $display("FAIL b2b_cnt fcnt=%0d scnt=%0d want 4/11", flush_cnt, stall_cnt); end
  endtask

  task automatic test_rst_wait();
    exc_req = 1'b1; exc_pc = 32'h0000_0055; stallreq = 6'b100000;
    step(); exc_req = 1'b0; #1;
    n_tests++; if (busy !== 1'b1 || flush !== 1'b0) begin n_fail++; $display("FAIL rstw_wait busy=%b flush=%b want 1/0", busy, flush); end
    rst = 1'b1; #1;
    n_tests++; if (stall !== 6'b000000) begin n_fail++; $display("FAIL rstw_forced got %b want 000000", stall); end
    step(); rst = 1'b0; stallreq = '0; #1;
    n_tests++; if (flush !== 1'b0 || busy !== 1'b0 || stall !== 6'b000000) begin n_fail++; $display("FAIL rstw_after flush=%b busy=%b stall=%b want 0/0/000000", flush, busy, stall); end
    n_tests++; if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0 || flush_pc !== 32'h0) begin n_fail++; $display("FAIL rstw_regs scnt=%0d fcnt=%0d pc=%h want 0/0/0", stall_cnt, flush_cnt, flush_pc); end
    for (int i = 0; i < 3; i++) begin
      step();
      n_tests++; if (flush !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rstw_noflush%0d flush=%b busy=%b want 0/0", i, flush, busy); end
    end
  endtask

  task automatic test_counter_sat();
    stallreq = 6'b000001;
    repeat (15) step();
    #1;
    n_tests++; if (stall_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_reach got %0d want 15", stall_cnt); end
    step(); #1;
    n_tests++; if (stall_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_hold got %0d want 15", stall_cnt); end
    cnt_clr = 1'b1;
    step(); cnt_clr = 1'b0; stallreq = '0; #1;
    n_tests++; if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin n_fail++; $display("FAIL clr_beats_inc scnt=%0d fcnt=%0d want 0/0", stall_cnt, flush_cnt); end
  endtask

  initial begin
    test_reset();
    test_load_stall();
    test_combined();
    test_clean_exc();
    test_drain();
    test_back_to_back();
    test_rst_wait();
    test_counter_sat();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end
endmodule
